// File: rtl/time_field_counter_pkg.sv
// time_pkg: definitions shared by the clock/calendar field counters.
//   SEL_*        select_item codes naming which field is being adjusted
//   rpt_state_e  states of the button auto-repeat FSM
package time_pkg;

  localparam logic [2:0] SEL_NONE  = 3'b000;
  localparam logic [2:0] SEL_SEC   = 3'b001;
  localparam logic [2:0] SEL_HOUR  = 3'b010;
  localparam logic [2:0] SEL_MIN   = 3'b011;
  localparam logic [2:0] SEL_DAY   = 3'b100;
  localparam logic [2:0] SEL_MONTH = 3'b101;
  localparam logic [2:0] SEL_YEAR  = 3'b110;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_HOLD,
    RPT_REPEAT
  } rpt_state_e;

endpackage

// File: rtl/time_field_counter_if.sv
// time_field_counter_if: signal bundle between the time chain and one field
// counter.
//   en, carry_in    counting enable and ripple carry from the lower field
//   select_item     adjust-target code
//   up, down        adjust buttons (levels, synchronous to clk_1Hz)
//   max_val         inclusive upper bound of the field
//   value           current field value
//   carry_out       one-cycle wrap pulse to the higher field
//   adj_active      field is currently selected for adjustment
// master drives the controls; slave is the field counter.
interface time_field_counter_if #(
  parameter int WIDTH = 6
);
  logic             en;
  logic             carry_in;
  logic [2:0]       select_item;
  logic             up;
  logic             down;
  logic [WIDTH-1:0] max_val;
  logic [WIDTH-1:0] value;
  logic             carry_out;
  logic             adj_active;

  modport master (
    output en, carry_in, select_item, up, down, max_val,
    input  value, carry_out, adj_active
  );

  modport slave (
    input  en, carry_in, select_item, up, down, max_val,
    output value, carry_out, adj_active
  );
endinterface

// File: rtl/time_field_counter_btn_repeat.sv
// btn_repeat: press detection and press-and-hold auto-repeat for the up/down
// adjust buttons of one time field.
//   clk_1Hz, rst_n        field clock, async active-low reset
//   clear_i               field not selected: FSM forced idle, no steps
//   up_i, down_i          button levels
//   step_up_o/step_down_o one-cycle step requests, valid in the cycle whose
//                         edge applies them
//
// state      | meaning
// -----------+--------------------------------------------------------
// RPT_IDLE   | waiting for a fresh press of exactly one button
// RPT_HOLD   | button held, counting toward the first repeat step
// RPT_REPEAT | button still held, stepping every REPEAT_PERIOD edges
module btn_repeat
  import time_pkg::*;
#(
  parameter int REPEAT_DELAY  = 3,
  parameter int REPEAT_PERIOD = 1
) (
  input  logic clk_1Hz,
  input  logic rst_n,
  input  logic clear_i,
  input  logic up_i,
  input  logic down_i,
  output logic step_up_o,
  output logic step_down_o
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(RPT_MAX + 1);
  localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  rpt_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;        // held button: 0 = up, 1 = down
  logic             up_prev_q, down_prev_q;
  logic             armed_q;             // set once a button level has been sampled since reset

  logic both, held_btn, other_btn, press_up, press_down, cnt_hit;

  assign both       = up_i & down_i;
  assign held_btn   = dir_q ? down_i : up_i;
  assign other_btn  = dir_q ? up_i : down_i;
  // A press needs the button seen low at a previous edge; after reset a
  // button that is already held must be released first.
  assign press_up   = armed_q & up_i & ~up_prev_q & ~down_i;
  assign press_down = armed_q & down_i & ~down_prev_q & ~up_i;
  assign cnt_hit    = (state_q == RPT_HOLD) ? (cnt_q >= DELAY_C) : (cnt_q >= PERIOD_C);

  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RPT_IDLE;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      up_prev_q   <= 1'b0;
      down_prev_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      // Button history keeps tracking while deselected so that returning
      // with a button still held is not mistaken for a press.
      up_prev_q   <= up_i;
      down_prev_q <= down_i;
      armed_q     <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    if (clear_i || both) begin
      state_d = RPT_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RPT_IDLE: begin
          if (press_up) begin
            state_d = RPT_HOLD;
            cnt_d   = ONE_C;
            dir_d   = 1'b0;
          end else if (press_down) begin
            state_d = RPT_HOLD;
            cnt_d   = ONE_C;
            dir_d   = 1'b1;
          end
        end
        RPT_HOLD, RPT_REPEAT: begin
          if (held_btn) begin
            if (cnt_hit) begin
              state_d = RPT_REPEAT;
              cnt_d   = ONE_C;
            end else begin
              cnt_d = cnt_q + ONE_C;
            end
          end else if (other_btn) begin
            // released one button while pressing the other: fresh press
            state_d = RPT_HOLD;
            cnt_d   = ONE_C;
            dir_d   = ~dir_q;
          end else begin
            state_d = RPT_IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = RPT_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    step_up_o   = 1'b0;
    step_down_o = 1'b0;
    if (!clear_i && !both) begin
      case (state_q)
        RPT_IDLE: begin
          step_up_o   = press_up;
          step_down_o = press_down;
        end
        RPT_HOLD, RPT_REPEAT: begin
          if (held_btn) begin
            if (cnt_hit) begin
              step_up_o   = ~dir_q;
              step_down_o = dir_q;
            end
          end else if (other_btn) begin
            step_up_o   = dir_q;
            step_down_o = ~dir_q;
          end
        end
        default: begin
          step_up_o   = 1'b0;
          step_down_o = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/time_field_counter.sv
// time_field_counter: adjustable modulo counter for one clock/calendar field.
// Counts on the carry from the lower field, wraps at a runtime bound and
// pulses carry_out for one cycle on wrap; when selected, up/down buttons step
// the value with auto-repeat.
//   clk_1Hz, rst_n  field clock, async active-low reset
//   bus (slave)     en, carry_in, select_item, up, down, max_val in;
//                   value, carry_out (registered), adj_active (comb) out
module time_field_counter
  import time_pkg::*;
#(
  parameter int         WIDTH         = 6,
  parameter int         MIN_VAL       = 0,
  parameter logic [2:0] SELECT_CODE   = SEL_HOUR,
  parameter int         REPEAT_DELAY  = 3,
  parameter int         REPEAT_PERIOD = 1
) (
  input  logic                 clk_1Hz,
  input  logic                 rst_n,
  time_field_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  logic             adj_active;
  logic             step_up, step_down;
  logic [WIDTH-1:0] value_q, value_d;
  logic             carry_q, carry_d;

  assign adj_active     = (bus.select_item == SELECT_CODE);
  assign bus.adj_active = adj_active;
  assign bus.value      = value_q;
  assign bus.carry_out  = carry_q;

  btn_repeat #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_btn_repeat (
    .clk_1Hz     (clk_1Hz),
    .rst_n       (rst_n),
    .clear_i     (!adj_active),
    .up_i        (bus.up),
    .down_i      (bus.down),
    .step_up_o   (step_up),
    .step_down_o (step_down)
  );

  // Wrap tests use >= / <= so a value left above a lowered bound never
  // increments past it.
  always_comb begin
    value_d = value_q;
    carry_d = 1'b0;
    if (adj_active) begin
      // carries arriving while the field is being set are dropped
      if (step_up) begin
        value_d = (value_q >= bus.max_val) ? MIN_V : value_q + ONE_V;
      end else if (step_down) begin
        value_d = (value_q <= MIN_V) ? bus.max_val : value_q - ONE_V;
      end else if (value_q > bus.max_val) begin
        value_d = bus.max_val;
      end
    end else if (bus.en && bus.carry_in) begin
      if (value_q >= bus.max_val) begin
        value_d = MIN_V;
        carry_d = 1'b1;
      end else begin
        value_d = value_q + ONE_V;
      end
    end else if (value_q > bus.max_val) begin
      value_d = bus.max_val;
    end
  end

  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= MIN_V;
      carry_q <= 1'b0;
    end else begin
      value_q <= value_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_time_field_counter.sv
module tb_time_field_counter;
  import time_pkg::*;

  // hour field: MIN 0, delay 3, period 1; day field: MIN 1, delay 2, period 2
  localparam int H_MIN = 0, H_DLY = 3, H_PER = 1;
  localparam int D_MIN = 1, D_DLY = 2, D_PER = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, cin = 1'b0, up = 1'b0, dn = 1'b0;
  logic [2:0] sel = SEL_NONE;
  logic [4:0] max_h = 5'd23, max_d = 5'd31;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  time_field_counter_if #(.WIDTH(5)) ifh ();
  time_field_counter_if #(.WIDTH(5)) ifd ();

  assign ifh.en = en;  assign ifh.carry_in = cin;  assign ifh.select_item = sel;
  assign ifh.up = up;  assign ifh.down = dn;        assign ifh.max_val = max_h;
  assign ifd.en = en;  assign ifd.carry_in = cin;  assign ifd.select_item = sel;
  assign ifd.up = up;  assign ifd.down = dn;        assign ifd.max_val = max_d;

  time_field_counter #(
    .WIDTH(5), .MIN_VAL(H_MIN), .SELECT_CODE(SEL_HOUR),
    .REPEAT_DELAY(H_DLY), .REPEAT_PERIOD(H_PER)
  ) u_hour (.clk_1Hz(clk), .rst_n(rst_n), .bus(ifh));

  time_field_counter #(
    .WIDTH(5), .MIN_VAL(D_MIN), .SELECT_CODE(SEL_DAY),
    .REPEAT_DELAY(D_DLY), .REPEAT_PERIOD(D_PER)
  ) u_day (.clk_1Hz(clk), .rst_n(rst_n), .bus(ifd));

  // Reference model: tracks which button is held and how many edges ago it
  // was pressed; steps fall at age 0, DELAY, DELAY+PERIOD, ...
  typedef struct {
    int v;
    bit c;
    bit pu, pd, seen;
    int held;   // 0 none, 1 up, 2 down
    int age;
  } mdl_t;

  mdl_t mh, md;

  function automatic mdl_t mdl_reset(int minv);
    mdl_t r;
    r.v = minv; r.c = 0; r.pu = 0; r.pd = 0; r.seen = 0; r.held = 0; r.age = 0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(mdl_t s, int minv, int maxv, int dly, int per,
                                    bit adj, bit en_b, bit cin_b, bit up_b, bit dn_b);
    mdl_t n = s;
    bit su = 0, sd = 0;
    n.c = 0;
    if (!adj || (up_b && dn_b)) begin
      n.held = 0; n.age = 0;
    end else if ((s.held == 1 && up_b) || (s.held == 2 && dn_b)) begin
      n.age = s.age + 1;
      if (n.age == dly || (n.age > dly && (n.age - dly) % per == 0)) begin
        if (s.held == 1) su = 1; else sd = 1;
      end
    end else if (up_b && (s.held == 2 || (s.held == 0 && s.seen && !s.pu))) begin
      su = 1; n.held = 1; n.age = 0;
    end else if (dn_b && (s.held == 1 || (s.held == 0 && s.seen && !s.pd))) begin
      sd = 1; n.held = 2; n.age = 0;
    end else begin
      n.held = 0; n.age = 0;
    end

    if (adj && su)      n.v = (s.v >= maxv) ? minv : s.v + 1;
    else if (adj && sd) n.v = (s.v <= minv) ? maxv : s.v - 1;
    else if (!adj && en_b && cin_b) begin
      if (s.v >= maxv) begin n.v = minv; n.c = 1; end
      else n.v = s.v + 1;
    end else if (s.v > maxv) n.v = maxv;

    n.pu = up_b; n.pd = dn_b; n.seen = 1;
    return n;
  endfunction

  task automatic chk(string tag, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("hour_value", int'(ifh.value), mh.v);
    chk("hour_carry", int'(ifh.carry_out), int'(mh.c));
    chk("hour_adj",   int'(ifh.adj_active), int'(sel == SEL_HOUR));
    chk("day_value",  int'(ifd.value), md.v);
    chk("day_carry",  int'(ifd.carry_out), int'(md.c));
    chk("day_adj",    int'(ifd.adj_active), int'(sel == SEL_DAY));
  endtask

  // One clk_1Hz edge: model follows the inputs the DUT samples, compare at negedge.
  task automatic cyc();
    @(posedge clk);
    mh = mdl_step(mh, H_MIN, int'(max_h), H_DLY, H_PER, sel == SEL_HOUR, en, cin, up, dn);
    md = mdl_step(md, D_MIN, int'(max_d), D_DLY, D_PER, sel == SEL_DAY, en, cin, up, dn);
    @(negedge clk);
    check_all();
  endtask

  task automatic run(int n);
    repeat (n) cyc();
  endtask

  // Called at a negedge; reset pulse finishes before the next posedge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    mh = mdl_reset(H_MIN);
    md = mdl_reset(D_MIN);
    check_all();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] sel_tab [4];
    sel_tab[0] = SEL_NONE; sel_tab[1] = SEL_HOUR; sel_tab[2] = SEL_DAY; sel_tab[3] = SEL_SEC;

    mh = mdl_reset(H_MIN);
    md = mdl_reset(D_MIN);
    #7 check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // counting with wrap at 23 and carry pulse
    en = 1; cin = 1;
    run(22);
    run(3);
    chk("hour_wrap_seq", int'(ifh.value), 1);
    run(5);
    chk("day_at_31", int'(ifd.value), 31);

    // bound falls below value: clamp with no carry
    en = 0; max_d = 5'd28;
    run(1);
    chk("day_clamp", int'(ifd.value), 28);
    en = 1;
    run(1);
    chk("day_wrap_to_min", int'(ifd.value), 1);
    en = 0;

    // down at minimum wraps to bound
    sel = SEL_DAY; dn = 1;
    run(1);
    chk("day_down_wrap", int'(ifd.value), 28);
    dn = 0;
    run(2);

    // adjust hour to 5 then hold up for auto-repeat
    sel = SEL_HOUR;
    dn = 1; run(1); dn = 0; run(1);
    dn = 1; run(1); dn = 0; run(1);
    chk("hour_at_5", int'(ifh.value), 5);
    up = 1;
    run(6);
    chk("hour_repeat", int'(ifh.value), 9);
    up = 0;
    run(3);
    chk("hour_released", int'(ifh.value), 9);

    // both buttons while counting would otherwise occur
    en = 1; cin = 1; up = 1; dn = 1;
    run(4);
    chk("hour_both", int'(ifh.value), 9);
    up = 0; dn = 0; en = 0;
    run(1);

    // reset mid-repeat with up held
    up = 1;
    run(6);
    do_reset();
    run(3);
    chk("hour_no_step_after_rst", int'(ifh.value), 0);
    up = 0; run(1);
    up = 1; run(2);

    // deselect during hold, return with button still high
    up = 0; run(1);
    up = 1; run(1);
    sel = SEL_NONE; en = 1; cin = 1;
    run(3);
    sel = SEL_HOUR; en = 0;
    run(3);
    up = 0; run(1);
    up = 1; run(1);
    up = 0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) sel = sel_tab[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) up = ~up;
      if ($urandom_range(0, 5) == 0) dn = ~dn;
      en  = 1'($urandom_range(0, 1));
      cin = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) max_h = 5'($urandom_range(15, 31));
      if ($urandom_range(0, 31) == 0) max_d = 5'($urandom_range(28, 31));
      cyc();
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/time_field_counter.md
# time_field_counter

Parametrised, adjustable modulo counter for one clock/calendar field: seconds, minutes, hours, day-of-month, month or year. It counts on a ripple carry from the next-lower field and emits a one-cycle carry to the next-higher field. The upper bound is a runtime input, so day-of-month tracks month length. When the field is selected for setting, up/down buttons step it with press-and-hold auto-repeat. It replaces the per-field fixed-range counters in the time chain.

## Interface
Parameters:
- WIDTH, 6, bit width of value and max_val
- MIN_VAL, 0, lowest legal value (1 for day/month); must satisfy MIN_VAL < 2**WIDTH
- SELECT_CODE, 3'b010, select_item code that puts this field in adjust mode
- REPEAT_DELAY, 3, clk_1Hz edges from press to first auto-repeat step; ≥1
- REPEAT_PERIOD, 1, clk_1Hz edges between later auto-repeat steps; ≥1

Ports:
- clk_1Hz  in  1  field clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  counting enable
- carry_in  in  1  carry from lower field (tie 1 for seconds)
- select_item  in  3  adjust-target code
- up  in  1  increment button, level, synchronous to clk_1Hz
- down  in  1  decrement button, level
- max_val  in  WIDTH  current upper bound, inclusive; ≥ MIN_VAL
- value  out  WIDTH  current field value
- carry_out  out  1  one-cycle wrap pulse to higher field
- adj_active  out  1  high while select_item == SELECT_CODE

## Operation
- Reset values: value = MIN_VAL, carry_out = 0, repeat FSM in IDLE, hold counter 0, previous-button registers 0. adj_active is combinational from select_item.
- Mode priority per edge: adjust (select match) > count (en && carry_in) > clamp > hold.
- Count mode:
  - if value ≥ max_val: value ← MIN_VAL, carry_out ← 1.
  - else value ← value+1, carry_out ← 0.
- Adjust mode:
  - carry_out ← 0 every edge; counting is suppressed, and a carry_in arriving in this mode is dropped.
  - A step up: value ≥ max_val → MIN_VAL, else +1.
  - A step down: value ≤ MIN_VAL → max_val, else −1.
- Clamp: if no count or step occurs and value > max_val (e.g. max_val fell 31→28), value ← max_val. No carry.
- Hold: all other cases keep value; carry_out ← 0.
- Repeat FSM states:
  - IDLE: exactly one button high and its previous sample low (press) → step once, go to HOLD, hold counter ← 1.
  - HOLD: same button still high → counter++. When counter reaches REPEAT_DELAY → step, go to REPEAT, counter ← 1. Release → IDLE.
  - REPEAT: same button still high → counter++. When counter reaches REPEAT_PERIOD → step, counter ← 1. Release → IDLE.
  - Both buttons high in any state → no step, go to IDLE. Re-arming requires a fresh press.
  - Held button released while the other is pressed on the same edge → treated as a new press of the other: step, go to HOLD.
- Leaving adjust mode forces the FSM to IDLE and counter to 0. Buttons are ignored outside adjust mode.
- Arithmetic is unsigned WIDTH-bit; wrap compares use ≥ / ≤ so out-of-range values never overflow.

## Timing
- All outputs except adj_active are registered; a state change is visible after the same edge that samples the cause.
- carry_out is high for exactly one clk_1Hz cycle, following the edge at which the wrap occurs.
- With REPEAT_DELAY = 3 and REPEAT_PERIOD = 1, press at edge E0 produces steps at E0, E0+3, E0+4, E0+5, ...
- rst_n asserted mid-hold or mid-carry clears immediately (asynchronously). After release, the first edge starts from IDLE, and a still-held button counts as a press only if it is seen low first.

## Structure
- Shared package time_pkg holds:
  - select codes SEL_NONE = 3'b000, SEL_SEC = 3'b001, SEL_HOUR = 3'b010, SEL_MIN = 3'b011, SEL_DAY = 3'b100, SEL_MONTH = 3'b101, SEL_YEAR = 3'b110;
  - the repeat FSM state enum {RPT_IDLE, RPT_HOLD, RPT_REPEAT}.
- Sub-module btn_repeat holds the edge detect, the repeat FSM and the hold counter. It outputs one-cycle step_up/step_down pulses, and its clear input is driven by !adj_active.
- The top level holds the value/carry datapath.

## Test plan
- Hour config (WIDTH = 5, max_val = 23), value = 22, en = carry_in = 1 for 3 edges → value 23, 0, 1; carry_out high only in the cycle after the 23→0 edge.
- Day config (MIN_VAL = 1), value = 31, max_val drops to 28 with en = 0 → value 28 after one edge, no carry. Then down at value 1 → 28.
- Adjust, up held 6 edges from value 5 (delay 3, period 1) → values 6, 6, 6, 7, 8, 9. Release → no further change.
- Adjust with en = carry_in = 1, up and down both held → value unchanged, carry_out stays 0.
- up held and rst_n pulsed low mid-REPEAT → value = MIN_VAL immediately. No step after reset until up goes low and high again.
- Switch select_item away during HOLD, then back with up still high → no step until re-press; counting resumes while deselected.
